// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the writeback stage.
// Load size/signedness encodings, datapath widths and the x0 index.
package wb_pkg;

  localparam int XLEN   = 64;
  localparam int REGW   = 6;
  localparam int REG_X0 = 0;

  // funct3 load encodings; 3'b111 is not named and behaves as LD
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } funct3_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational byte-lane shift and sign/zero extension of a
// doubleword read. Bytes beyond the doubleword (boundary-crossing access)
// come in as zero from the logical shift; no fault is produced.
module load_align #(
  parameter int XLEN = wb_pkg::XLEN
) (
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);
  import wb_pkg::*;

  logic [XLEN-1:0] shifted;

  // Shift the addressed byte down to lane 0, then extend by load size
  always_comb begin
    shifted = mem_data >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}},        shifted[15:0]};
      F3_LWU:  result = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: result = shifted;  // LD and the unnamed 3'b111
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, result selection, register-file
// write port and retired-instruction counter.
// Optional macro WB_FWD_EN adds a writeback-to-decode bypass
// (fwd_rs1/fwd_rs2 in, fwd_hit1/fwd_hit2/fwd_data out).
module wb_stage #(
  parameter int XLEN = wb_pkg::XLEN,
  parameter int REGW = wb_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  input  logic            m_ctrl_regwr,
  input  logic            m_mem2reg,
  input  logic [XLEN-1:0] m_alu_result,
  input  logic [XLEN-1:0] m_mem_data,
  input  logic [2:0]      m_funct3,
  input  logic [REGW-1:0] m_wr_reg,
  input  logic            wb_stall,
  input  logic            wb_flush,
  output logic            w_regwr,
  output logic [XLEN-1:0] w_write_data,
  output logic [REGW-1:0] w_wr_reg,
  output logic            w_valid,
  output logic [31:0]     w_retire_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data
`endif
);
  import wb_pkg::*;

  logic            valid_q, valid_d;
  logic            regwr_q, regwr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [REGW-1:0] wr_reg_q, wr_reg_d;
  logic [31:0]     retire_cnt_q, retire_cnt_d;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_result;

  load_align #(.XLEN(XLEN)) u_load_align (
    .mem_data (m_mem_data),
    .offset   (m_alu_result[2:0]),
    .funct3   (m_funct3),
    .result   (load_val)
  );

  // Select load data or ALU result ahead of the pipeline register
  always_comb begin
    wb_result = m_mem2reg ? load_val : m_alu_result;
  end

  // Capture rule: flush/stall inject a bubble, otherwise take MEM
  always_comb begin
    valid_d      = valid_q;
    regwr_d      = regwr_q;
    data_d       = data_q;
    wr_reg_d     = wr_reg_q;
    retire_cnt_d = retire_cnt_q + {31'd0, valid_q};
    if (wb_flush || wb_stall) begin
      valid_d = 1'b0;
    end else begin
      valid_d  = m_valid;
      regwr_d  = m_ctrl_regwr;
      data_d   = wb_result;
      wr_reg_d = m_wr_reg;
    end
  end

  // MEM/WB register and retire counter; reset drops any held instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwr_q      <= 1'b0;
      data_q       <= '0;
      wr_reg_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      regwr_q      <= regwr_d;
      data_q       <= data_d;
      wr_reg_q     <= wr_reg_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Register-file write port; writes to x0 are suppressed
  always_comb begin
    w_regwr      = valid_q & regwr_q & (wr_reg_q != REGW'(REG_X0));
    w_write_data = data_q;
    w_wr_reg     = wr_reg_q;
    w_valid      = valid_q;
    w_retire_cnt = retire_cnt_q;
  end

`ifdef WB_FWD_EN
  // Same-cycle bypass for decode reads that hit the register being written
  always_comb begin
    fwd_hit1 = w_regwr & (wr_reg_q[4:0] == fwd_rs1) & (fwd_rs1 != 5'd0);
    fwd_hit2 = w_regwr & (wr_reg_q[4:0] == fwd_rs2) & (fwd_rs2 != 5'd0);
    fwd_data = data_q;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven checks of wb_stage plus hand-written
// sequences for stall/flush bubbles, async reset and counter wrap.
// Forwarding checks are compiled when WB_FWD_EN is defined.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_ctrl_regwr = 1'b0;
  logic        m_mem2reg = 1'b0;
  logic [63:0] m_alu_result = '0;
  logic [63:0] m_mem_data = '0;
  logic [2:0]  m_funct3 = '0;
  logic [5:0]  m_wr_reg = '0;
  logic        wb_stall = 1'b0;
  logic        wb_flush = 1'b0;
  logic        w_regwr;
  logic [63:0] w_write_data;
  logic [5:0]  w_wr_reg;
  logic        w_valid;
  logic [31:0] w_retire_cnt;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1 = '0;
  logic [4:0]  fwd_rs2 = '0;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [63:0] fwd_data;
`endif

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .m_valid      (m_valid),
    .m_ctrl_regwr (m_ctrl_regwr),
    .m_mem2reg    (m_mem2reg),
    .m_alu_result (m_alu_result),
    .m_mem_data   (m_mem_data),
    .m_funct3     (m_funct3),
    .m_wr_reg     (m_wr_reg),
    .wb_stall     (wb_stall),
    .wb_flush     (wb_flush),
    .w_regwr      (w_regwr),
    .w_write_data (w_write_data),
    .w_wr_reg     (w_wr_reg),
    .w_valid      (w_valid),
    .w_retire_cnt (w_retire_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data     (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state for valid and the retire count
  logic        exp_valid = 1'b0;
  logic [31:0] exp_cnt   = '0;

  typedef struct {
    string       name;
    logic        regwr;
    logic        mem2reg;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [2:0]  f3;
    logic [5:0]  rd;
    logic [63:0] exp_data;
    logic        exp_regwr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: inputs already driven, model advances, outputs settle 1ns later
  task automatic step();
    exp_cnt   = exp_cnt + {31'd0, exp_valid};
    exp_valid = m_valid & ~wb_stall & ~wb_flush;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    m_valid      = 1'b1;
    m_ctrl_regwr = v.regwr;
    m_mem2reg    = v.mem2reg;
    m_alu_result = v.alu;
    m_mem_data   = v.mem;
    m_funct3     = v.f3;
    m_wr_reg     = v.rd;
  endtask

  initial begin
    vecs[0]  = '{"alu_1234",  1'b1, 1'b0, 64'h1234, 64'h0, 3'b000, 6'd5, 64'h1234, 1'b1};
    vecs[1]  = '{"lb_off2",   1'b1, 1'b1, 64'h2, 64'h0000_0000_80FF_0000, 3'b000, 6'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2]  = '{"lbu_off2",  1'b1, 1'b1, 64'h2, 64'h0000_0000_80FF_0000, 3'b100, 6'd7, 64'h0000_0000_0000_00FF, 1'b1};
    vecs[3]  = '{"lh_off2",   1'b1, 1'b1, 64'h2, 64'h0000_0000_80FF_0000, 3'b001, 6'd8, 64'hFFFF_FFFF_FFFF_80FF, 1'b1};
    vecs[4]  = '{"lhu_off2",  1'b1, 1'b1, 64'h2, 64'h0000_0000_80FF_0000, 3'b101, 6'd9, 64'h0000_0000_0000_80FF, 1'b1};
    vecs[5]  = '{"x0_write",  1'b1, 1'b0, 64'h55, 64'h0, 3'b000, 6'd0, 64'h55, 1'b0};
    vecs[6]  = '{"lw_cross6", 1'b1, 1'b1, 64'h1006, 64'hAABB_1122_3344_5566, 3'b010, 6'd10, 64'h0000_0000_0000_AABB, 1'b1};
    vecs[7]  = '{"ld_off0",   1'b1, 1'b1, 64'h2000, 64'h8000_0000_0000_0001, 3'b011, 6'd11, 64'h8000_0000_0000_0001, 1'b1};
    vecs[8]  = '{"f3_111",    1'b1, 1'b1, 64'h2000, 64'h8000_0000_0000_0001, 3'b111, 6'd12, 64'h8000_0000_0000_0001, 1'b1};
    vecs[9]  = '{"lw_off4",   1'b1, 1'b1, 64'h4, 64'h8000_0001_1234_5678, 3'b010, 6'd13, 64'hFFFF_FFFF_8000_0001, 1'b1};
    vecs[10] = '{"lwu_off4",  1'b1, 1'b1, 64'h4, 64'h8000_0001_1234_5678, 3'b110, 6'd14, 64'h0000_0000_8000_0001, 1'b1};
    vecs[11] = '{"lh_cross7", 1'b1, 1'b1, 64'h7, 64'hFF00_0000_0000_0000, 3'b001, 6'd33, 64'h0000_0000_0000_00FF, 1'b1};
    vecs[12] = '{"no_regwr",  1'b0, 1'b0, 64'h77, 64'h0, 3'b000, 6'd15, 64'h77, 1'b0};

    // Reset state
    #12;
    chk("rst_valid", {63'd0, w_valid}, 64'd0);
    chk("rst_regwr", {63'd0, w_regwr}, 64'd0);
    chk("rst_data", w_write_data, 64'd0);
    chk("rst_wr_reg", {58'd0, w_wr_reg}, 64'd0);
    chk("rst_cnt", {32'd0, w_retire_cnt}, 64'd0);
`ifdef WB_FWD_EN
    chk("rst_fwd_data", fwd_data, 64'd0);
    chk("rst_fwd_hit1", {63'd0, fwd_hit1}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors, one instruction per cycle
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      step();
      chk({vecs[i].name, "_valid"}, {63'd0, w_valid}, 64'd1);
      chk({vecs[i].name, "_regwr"}, {63'd0, w_regwr}, {63'd0, vecs[i].exp_regwr});
      chk({vecs[i].name, "_data"}, w_write_data, vecs[i].exp_data);
      chk({vecs[i].name, "_wr_reg"}, {58'd0, w_wr_reg}, {58'd0, vecs[i].rd});
      chk({vecs[i].name, "_cnt"}, {32'd0, w_retire_cnt}, {32'd0, exp_cnt});
    end

    // Stall two cycles with a valid MEM instruction: two bubbles, data held
    drive(vecs[0]);
    wb_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_valid", {63'd0, w_valid}, 64'd0);
      chk("stall_regwr", {63'd0, w_regwr}, 64'd0);
      chk("stall_data_held", w_write_data, 64'h77);
      chk("stall_cnt", {32'd0, w_retire_cnt}, {32'd0, exp_cnt});
    end
    chk("stall_cnt_frozen", {32'd0, w_retire_cnt}, 64'd13);
    // Flush together with stall, then flush alone
    wb_flush = 1'b1;
    step();
    chk("flush_stall_valid", {63'd0, w_valid}, 64'd0);
    chk("flush_stall_regwr", {63'd0, w_regwr}, 64'd0);
    wb_stall = 1'b0;
    step();
    chk("flush_valid", {63'd0, w_valid}, 64'd0);
    chk("flush_cnt", {32'd0, w_retire_cnt}, 64'd13);
    wb_flush = 1'b0;

    // Back-to-back writes to x5: each written once, in order
    drive(vecs[0]);
    m_alu_result = 64'hA1;
    step();
    chk("b2b_first", w_write_data, 64'hA1);
    m_alu_result = 64'hB2;
    step();
    chk("b2b_second", w_write_data, 64'hB2);
    chk("b2b_regwr", {63'd0, w_regwr}, 64'd1);

`ifdef WB_FWD_EN
    // WB writing x7 with 0xDEAD; decode reads x7 and x0
    drive(vecs[0]);
    m_alu_result = 64'hDEAD;
    m_wr_reg     = 6'd7;
    step();
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    #1;
    chk("fwd_hit1", {63'd0, fwd_hit1}, 64'd1);
    chk("fwd_hit2_x0", {63'd0, fwd_hit2}, 64'd0);
    chk("fwd_data", fwd_data, 64'hDEAD);
    fwd_rs2 = 5'd8;
    #1;
    chk("fwd_hit2_miss", {63'd0, fwd_hit2}, 64'd0);
    fwd_rs1 = 5'd0;
    fwd_rs2 = 5'd0;
`endif

    // Async reset mid-cycle while a write is pending
    drive(vecs[0]);
    m_wr_reg = 6'd3;
    step();
    chk("pre_rst_regwr", {63'd0, w_regwr}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_regwr", {63'd0, w_regwr}, 64'd0);
    chk("arst_valid", {63'd0, w_valid}, 64'd0);
    chk("arst_data", w_write_data, 64'd0);
    chk("arst_wr_reg", {58'd0, w_wr_reg}, 64'd0);
    chk("arst_cnt", {32'd0, w_retire_cnt}, 64'd0);
    exp_valid = 1'b0;
    exp_cnt   = '0;
    m_valid   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_valid", {63'd0, w_valid}, 64'd0);
    chk("post_rst_cnt", {32'd0, w_retire_cnt}, 64'd0);

    // Counter wrap: preload 0xFFFF_FFFF, retire one instruction
    drive(vecs[0]);
    step();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    exp_cnt = 32'hFFFF_FFFF;
    chk("wrap_preload", {32'd0, w_retire_cnt}, {32'd0, exp_cnt});
    m_valid = 1'b0;
    step();
    chk("wrap_zero", {32'd0, w_retire_cnt}, {32'd0, exp_cnt});
    chk("wrap_zero_const", {32'd0, w_retire_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
